// File: rtl/cond_flag_unit.sv
`default_nettype none
// ============================================================================
// Module   : cond_flag_unit
// Brief    : Architectural ZNCV flag register, condition evaluator and EX/MEM
//            gating of write-enables / branch decision with a squash counter.
// Revision : 1.0 - initial release
// ============================================================================
module cond_flag_unit #(
    parameter logic [3:0] RESET_FLAGS = 4'b0000,
    parameter int         CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    input  logic             flush,
    input  logic             ex_valid,
    input  logic [3:0]       ex_cond,
    input  logic             ex_set_flags,
    input  logic [3:0]       alu_flags,
    input  logic             ex_reg_write,
    input  logic             ex_mem_write,
    input  logic             ex_branch,
    output logic             cond_pass,
    output logic [3:0]       flags_q,
    output logic             mem_valid,
    output logic             mem_reg_write,
    output logic             mem_mem_write,
    output logic             branch_taken,
    output logic [CNT_W-1:0] squash_cnt
);

    localparam logic [3:0] c_COND_EQ = 4'd0;
    localparam logic [3:0] c_COND_NE = 4'd1;
    localparam logic [3:0] c_COND_CS = 4'd2;
    localparam logic [3:0] c_COND_CC = 4'd3;
    localparam logic [3:0] c_COND_MI = 4'd4;
    localparam logic [3:0] c_COND_PL = 4'd5;
    localparam logic [3:0] c_COND_VS = 4'd6;
    localparam logic [3:0] c_COND_VC = 4'd7;
    localparam logic [3:0] c_COND_HI = 4'd8;
    localparam logic [3:0] c_COND_LS = 4'd9;
    localparam logic [3:0] c_COND_GE = 4'd10;
    localparam logic [3:0] c_COND_LT = 4'd11;
    localparam logic [3:0] c_COND_GT = 4'd12;
    localparam logic [3:0] c_COND_LE = 4'd13;
    localparam logic [3:0] c_COND_AL = 4'd14;
    localparam logic [3:0] c_COND_NV = 4'd15;

    localparam logic [CNT_W-1:0] c_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [3:0]       r_flags;
    logic             r_mem_valid;
    logic             r_mem_reg_write;
    logic             r_mem_mem_write;
    logic             r_branch_taken;
    logic [CNT_W-1:0] r_squash_cnt;

    logic w_z;
    logic w_n;
    logic w_c;
    logic w_v;
    logic w_pass;
    logic w_commit;
    logic w_squash;
    logic w_cnt_sat;

    assign w_z = r_flags[3];
    assign w_n = r_flags[2];
    assign w_c = r_flags[1];
    assign w_v = r_flags[0];

    // Decode reads the committed register directly, so a flag write in one
    // EX cycle is seen by the next instruction without a bypass path.
    always_comb begin
        w_pass = 1'b0;
        case (ex_cond)
            c_COND_EQ: w_pass = w_z;
            c_COND_NE: w_pass = ~w_z;
            c_COND_CS: w_pass = w_c;
            c_COND_CC: w_pass = ~w_c;
            c_COND_MI: w_pass = w_n;
            c_COND_PL: w_pass = ~w_n;
            c_COND_VS: w_pass = w_v;
            c_COND_VC: w_pass = ~w_v;
            c_COND_HI: w_pass = w_c & ~w_z;
            c_COND_LS: w_pass = ~w_c | w_z;
            c_COND_GE: w_pass = (w_n == w_v);
            c_COND_LT: w_pass = (w_n != w_v);
            c_COND_GT: w_pass = ~w_z & (w_n == w_v);
            c_COND_LE: w_pass = w_z | (w_n != w_v);
            c_COND_AL: w_pass = 1'b1;
            c_COND_NV: w_pass = 1'b0;
        endcase
    end

    assign w_commit  = ex_valid & w_pass & ~flush & ~stall;
    assign w_squash  = ex_valid & ~w_pass & ~flush;
    assign w_cnt_sat = &r_squash_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_flags         <= RESET_FLAGS;
            r_mem_valid     <= 1'b0;
            r_mem_reg_write <= 1'b0;
            r_mem_mem_write <= 1'b0;
            r_branch_taken  <= 1'b0;
            r_squash_cnt    <= '0;
        end else if (!stall) begin
            r_mem_valid     <= w_commit;
            r_mem_reg_write <= w_commit & ex_reg_write;
            r_mem_mem_write <= w_commit & ex_mem_write;
            r_branch_taken  <= w_commit & ex_branch;
            if (w_commit && ex_set_flags) begin
                r_flags <= alu_flags;
            end
            if (w_squash && !w_cnt_sat) begin
                r_squash_cnt <= r_squash_cnt + c_CNT_ONE;
            end
        end
    end

    assign cond_pass     = w_pass;
    assign flags_q       = r_flags;
    assign mem_valid     = r_mem_valid;
    assign mem_reg_write = r_mem_reg_write;
    assign mem_mem_write = r_mem_mem_write;
    assign branch_taken  = r_branch_taken;
    assign squash_cnt    = r_squash_cnt;

endmodule
`default_nettype wire

// File: tb/tb_cond_flag_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_cond_flag_unit
// Brief    : Directed plus random bench for cond_flag_unit against a
//            behavioural instruction-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cond_flag_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic        ex_valid = 1'b0;
    logic [3:0]  ex_cond = 4'd0;
    logic        ex_set_flags = 1'b0;
    logic [3:0]  alu_flags = 4'd0;
    logic        ex_reg_write = 1'b0;
    logic        ex_mem_write = 1'b0;
    logic        ex_branch = 1'b0;

    logic        cond_pass;
    logic [3:0]  flags_q;
    logic        mem_valid;
    logic        mem_reg_write;
    logic        mem_mem_write;
    logic        branch_taken;
    logic [15:0] squash_cnt;

    logic        cond_pass4;
    logic [3:0]  flags_q4;
    logic        mem_valid4;
    logic        mem_reg_write4;
    logic        mem_mem_write4;
    logic        branch_taken4;
    logic [3:0]  squash_cnt4;

    int total = 0;
    int bad   = 0;

    // behavioural model state
    logic [3:0] m_flags;
    logic       m_valid, m_rw, m_mw, m_br;
    int         m_cnt;

    always #5 clk = ~clk;

    cond_flag_unit #(.RESET_FLAGS(4'b0000), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
        .ex_valid(ex_valid), .ex_cond(ex_cond), .ex_set_flags(ex_set_flags),
        .alu_flags(alu_flags), .ex_reg_write(ex_reg_write),
        .ex_mem_write(ex_mem_write), .ex_branch(ex_branch),
        .cond_pass(cond_pass), .flags_q(flags_q), .mem_valid(mem_valid),
        .mem_reg_write(mem_reg_write), .mem_mem_write(mem_mem_write),
        .branch_taken(branch_taken), .squash_cnt(squash_cnt)
    );

    cond_flag_unit #(.RESET_FLAGS(4'b0000), .CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
        .ex_valid(ex_valid), .ex_cond(ex_cond), .ex_set_flags(ex_set_flags),
        .alu_flags(alu_flags), .ex_reg_write(ex_reg_write),
        .ex_mem_write(ex_mem_write), .ex_branch(ex_branch),
        .cond_pass(cond_pass4), .flags_q(flags_q4), .mem_valid(mem_valid4),
        .mem_reg_write(mem_reg_write4), .mem_mem_write(mem_mem_write4),
        .branch_taken(branch_taken4), .squash_cnt(squash_cnt4)
    );

    function automatic logic cond_eval(input logic [3:0] code, input logic [3:0] f);
        bit z, n, c, v;
        z = f[3]; n = f[2]; c = f[1]; v = f[0];
        case (code)
            4'd0:  return z;
            4'd1:  return !z;
            4'd2:  return c;
            4'd3:  return !c;
            4'd4:  return n;
            4'd5:  return !n;
            4'd6:  return v;
            4'd7:  return !v;
            4'd8:  return c && !z;
            4'd9:  return !c || z;
            4'd10: return n == v;
            4'd11: return n != v;
            4'd12: return !z && (n == v);
            4'd13: return z || (n != v);
            4'd14: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_flags = 4'b0000;
        m_valid = 1'b0; m_rw = 1'b0; m_mw = 1'b0; m_br = 1'b0;
        m_cnt   = 0;
    endtask

    task automatic check_regs(input string tag);
        chk({tag, ".flags"},   {28'd0, flags_q},    {28'd0, m_flags});
        chk({tag, ".valid"},   {31'd0, mem_valid},  {31'd0, m_valid});
        chk({tag, ".rw"},      {31'd0, mem_reg_write}, {31'd0, m_rw});
        chk({tag, ".mw"},      {31'd0, mem_mem_write}, {31'd0, m_mw});
        chk({tag, ".br"},      {31'd0, branch_taken},  {31'd0, m_br});
        chk({tag, ".cnt16"},   {16'd0, squash_cnt},
            (m_cnt > 65535) ? 32'd65535 : 32'(m_cnt));
        chk({tag, ".cnt4"},    {28'd0, squash_cnt4},
            (m_cnt > 15) ? 32'd15 : 32'(m_cnt));
    endtask

    // One EX cycle: drive, check decode, clock, update model, check registers.
    task automatic step(input string tag, input logic st, input logic fl,
                        input logic v, input logic [3:0] cond, input logic sf,
                        input logic [3:0] af, input logic rw, input logic mw,
                        input logic br);
        logic p;
        stall = st; flush = fl; ex_valid = v; ex_cond = cond;
        ex_set_flags = sf; alu_flags = af; ex_reg_write = rw;
        ex_mem_write = mw; ex_branch = br;
        #1;
        p = cond_eval(cond, m_flags);
        chk({tag, ".pass"}, {31'd0, cond_pass}, {31'd0, p});
        @(posedge clk);
        if (!st) begin
            m_valid = v && p && !fl;
            m_rw    = m_valid && rw;
            m_mw    = m_valid && mw;
            m_br    = m_valid && br;
            if (m_valid && sf) m_flags = af;
            if (v && !p && !fl) m_cnt++;
        end
        #1;
        check_regs(tag);
    endtask

    task automatic async_reset(input string tag);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_regs(tag);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin : stim
        logic [3:0] sweep_flags [6];
        sweep_flags[0] = 4'b1000; sweep_flags[1] = 4'b0100;
        sweep_flags[2] = 4'b0010; sweep_flags[3] = 4'b0001;
        sweep_flags[4] = 4'b0101; sweep_flags[5] = 4'b1010;

        // reset state seen while rst_n is still low
        model_reset();
        #2;
        check_regs("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // condition sweep: load flags, then evaluate every code with ex_valid=0
        for (int i = 0; i < 6; i++) begin
            step("sweep.load", 0, 0, 1, 4'd14, 1, sweep_flags[i], 0, 0, 0);
            for (int c = 0; c < 16; c++) begin
                step("sweep", 0, 0, 0, 4'(c), 1, 4'($urandom), 1, 1, 1);
            end
        end

        // flag update chain
        step("chain.c1", 0, 0, 1, 4'd14, 1, 4'b1000, 0, 0, 0);
        step("chain.c2", 0, 0, 1, 4'd0,  0, 4'b0000, 1, 0, 0);
        chk("chain.rw_late", {31'd0, mem_reg_write}, 32'd1);

        // squash: NE fails with Z=1
        step("squash", 0, 0, 1, 4'd1, 1, 4'b0000, 0, 1, 0);
        chk("squash.flags_kept", {28'd0, flags_q}, 32'h8);
        chk("squash.cnt", {16'd0, squash_cnt}, 32'd1);

        // stall and flush
        step("sf.br", 0, 0, 1, 4'd14, 0, 4'b0000, 0, 0, 1);
        for (int k = 0; k < 3; k++) begin
            step("sf.stall", 1, 0, 1, 4'd14, 1, 4'b0110, 1, 1, 1);
        end
        step("sf.stall_fail", 1, 0, 1, 4'd15, 0, 4'b0000, 0, 0, 0);
        chk("sf.stall_br_held", {31'd0, branch_taken}, 32'd1);
        step("sf.flush", 0, 1, 1, 4'd14, 1, 4'b0110, 1, 1, 1);
        chk("sf.flush_br", {31'd0, branch_taken}, 32'd0);
        step("sf.flush_fail", 0, 1, 1, 4'd15, 1, 4'b0110, 0, 0, 0);
        step("sf.br2", 0, 0, 1, 4'd14, 0, 4'b0000, 0, 0, 1);
        step("sf.both", 1, 1, 1, 4'd14, 1, 4'b0011, 1, 1, 1);

        // random traffic
        for (int r = 0; r < 400; r++) begin
            step("rand", ($urandom_range(0, 4) == 0), ($urandom_range(0, 9) == 0),
                 ($urandom_range(0, 3) != 0), 4'($urandom), 1'($urandom),
                 4'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
        end

        // saturation of the narrow counter
        async_reset("reset.mid");
        for (int s = 0; s < 20; s++) begin
            step("sat", 0, 0, 1, 4'd15, 1, 4'b1111, 1, 1, 1);
        end
        chk("sat.cnt4", {28'd0, squash_cnt4}, 32'd15);
        chk("sat.cnt16", {16'd0, squash_cnt}, 32'd20);

        // reset while stalled and flushing
        step("pre", 0, 0, 1, 4'd14, 1, 4'b0101, 1, 1, 1);
        stall = 1'b1; flush = 1'b1;
        async_reset("reset.stall");
        step("post", 0, 0, 1, 4'd10, 0, 4'b0000, 1, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cond_flag_unit.md
Name: cond_flag_unit

Overview:
- Consumer side of the ALU flag interface: holds the architectural flag register written by the ALU and evaluates each execute-stage instruction's 4-bit condition field against it.
- Sits between EX and MEM. Registers the gated write-enables and branch decision into the EX/MEM boundary.
- Counts instructions squashed by a failed condition.
- Flag bus order everywhere: bit3=Z, bit2=N, bit1=C, bit0=V (same as the ALU flag output).

Parameters:
- RESET_FLAGS, 4'b0000, value loaded into the flag register on reset.
- CNT_W, 16, width of the squashed-instruction counter.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- stall  input  1  hold all state; the EX instruction does not advance
- flush  input  1  kill the EX instruction (it does not commit)
- ex_valid  input  1  EX stage holds a real instruction
- ex_cond  input  4  condition field
- ex_set_flags  input  1  instruction updates flags (S bit)
- alu_flags  input  4  ZNCV from the ALU for the EX instruction
- ex_reg_write  input  1  instruction requests register write
- ex_mem_write  input  1  instruction requests memory write
- ex_branch  input  1  instruction is a branch
- cond_pass  output  1  combinational: condition true against flags_q
- flags_q  output  4  architectural flag register
- mem_valid  output  1  registered: committed instruction present in MEM
- mem_reg_write  output  1  registered gated register-write enable
- mem_mem_write  output  1  registered gated memory-write enable
- branch_taken  output  1  registered: branch executed
- squash_cnt  output  CNT_W  saturating count of condition-failed valid instructions

Behaviour:
- Reset (rst_n=0, asynchronous): flags_q=RESET_FLAGS; mem_valid, mem_reg_write, mem_mem_write, branch_taken=0; squash_cnt=0. Reset mid-stall or mid-flush overrides everything.
- Condition decode uses current flags_q (Z,N,C,V), combinationally. Codes are: 0 EQ Z; 1 NE !Z; 2 CS C; 3 CC !C; 4 MI N; 5 PL !N; 6 VS V; 7 VC !V; 8 HI C&!Z; 9 LS !C|Z; 10 GE N==V; 11 LT N!=V; 12 GT !Z&(N==V); 13 LE Z|(N!=V); 14 AL 1; 15 NV 0.
- cond_pass is the decoded value, independent of ex_valid.
- commit = ex_valid & cond_pass & !flush & !stall.
- Rising edge, stall=1: all registers hold, including flags_q and squash_cnt. stall takes precedence over flush.
- Rising edge, stall=0:
  - mem_valid <= commit.
  - mem_reg_write <= commit & ex_reg_write.
  - mem_mem_write <= commit & ex_mem_write.
  - branch_taken <= commit & ex_branch.
  - Flag write: if commit & ex_set_flags, flags_q <= alu_flags; otherwise flags_q holds.
  - Counter: if ex_valid & !cond_pass & !flush, squash_cnt <= squash_cnt+1, saturating at all-ones (no wrap).
- Latency:
  - Gated enables appear 1 cycle after the EX cycle.
  - A flag update is visible to cond_pass in the very next EX cycle; back-to-back dependent instructions need no forwarding.
- A failed-condition instruction never writes flags, even with ex_set_flags=1.
- flush with ex_valid=1: no commit, no count, flags unchanged.
- ex_valid=0: alu_flags and the request inputs are ignored.
- No X propagation: every output is driven from a register or from flags_q and ex_cond only.

Test Plan:
- Reset and async assert: pulse rst_n low mid-cycle with RESET_FLAGS=4'b0000 -> flags_q=0000, all mem_* outputs=0, squash_cnt=0 immediately, without waiting for a clock edge.
- Condition sweep: for each flags_q in {1000,0100,0010,0001,0101,1010}, drive all 16 ex_cond -> cond_pass matches the table. Example: flags 0101 (N=1,V=1): GE=1, LT=0, GT=1, LE=0; code 15 is always 0.
- Flag update chain:
  - Cycle 1: cond=AL, set_flags=1, alu_flags=1000.
  - Cycle 2: cond=EQ, reg_write=1.
  - Required: flags_q=1000 after cycle 1; cond_pass=1 in cycle 2; mem_reg_write=1 one cycle later.
- Squash: flags_q=1000, ex_valid=1, cond=NE, set_flags=1, alu_flags=0000, mem_write=1 -> mem_mem_write=0, mem_valid=0, flags_q stays 1000, squash_cnt increments by 1.
- Stall and flush:
  - stall=1 for 3 cycles with a passing branch -> branch_taken and flags_q unchanged, squash_cnt unchanged.
  - Then flush=1 with stall=0 -> branch_taken=0, no flag write.
  - stall=1 & flush=1 together -> hold.
- Counter saturation: CNT_W=4, drive 20 consecutive failing valid instructions -> squash_cnt reaches 15 and stays 15.
